// File: rtl/gt_message_router.sv
// Inter-FPGA message router: round-robin egress onto the GT link with header
// rewrite, and a one-entry ingress holding register that classifies and multicasts.
module gt_message_router #(
    parameter int                        GT_WIDTH     = 64,
    parameter int                        DEST_MSB     = 63,
    parameter int                        DEST_LSB     = 56,
    parameter int                        DIR_BIT      = 55,
    parameter int                        TAG_MSB      = 54,
    parameter int                        TAG_LSB      = 48,
    parameter logic [TAG_MSB-TAG_LSB:0]  CTRL_TAG     = 7'h7F,
    parameter logic [7:0]                BROADCAST_ID = 8'hFF,
    parameter bit                        RELAY_EN     = 1'b1,
    parameter int                        CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           fpga_id,
    input  logic [GT_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [GT_WIDTH-1:0]  out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic [GT_WIDTH-1:0]  north_in_data,
    input  logic                 north_in_valid,
    output logic                 north_in_ready,
    input  logic [GT_WIDTH-1:0]  south_in_data,
    input  logic                 south_in_valid,
    output logic                 south_in_ready,
    input  logic [GT_WIDTH-1:0]  ctrl_in_data,
    input  logic                 ctrl_in_valid,
    output logic                 ctrl_in_ready,
    output logic [GT_WIDTH-1:0]  north_out_data,
    output logic                 north_out_valid,
    input  logic                 north_out_ready,
    output logic [GT_WIDTH-1:0]  south_out_data,
    output logic                 south_out_valid,
    input  logic                 south_out_ready,
    output logic [GT_WIDTH-1:0]  ctrl_out_data,
    output logic                 ctrl_out_valid,
    input  logic                 ctrl_out_ready,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 router_busy
);

    // Source/target slot indices: 0 north, 1 south, 2 control, 3 relay.
    localparam int NSRC = RELAY_EN ? 4 : 3;

    logic [7:0]                 north_id_r;
    logic [7:0]                 south_id_r;
    logic [GT_WIDTH-1:0]        out_data_r;
    logic                       out_valid_r;
    logic [1:0]                 ptr_r;
    logic [GT_WIDTH-1:0]        hold_data_r;
    logic                       hold_valid_r;
    logic [3:0]                 done_r;
    logic [CNT_WIDTH-1:0]       drop_cnt_r;

    logic                       load_s;
    logic [7:0]                 dest_s;
    logic [TAG_MSB-TAG_LSB:0]   tag_s;
    logic [3:0]                 sel_s;
    logic                       drop_s;
    logic [3:0]                 tgt_valid_s;
    logic [3:0]                 req_s;
    logic                       gnt_any_s;
    logic [1:0]                 gnt_idx_s;
    logic [1:0]                 ptr_next_s;
    int                         idx_s;
    logic                       take_s;
    logic [3:0]                 src_ready_s;
    logic [3:0]                 hs_s;
    logic                       complete_s;
    logic                       in_ready_s;
    logic [GT_WIDTH-1:0]        egress_word_s;

    assign load_s = !out_valid_r || out_ready;
    assign dest_s = hold_data_r[DEST_MSB:DEST_LSB];
    assign tag_s  = hold_data_r[TAG_MSB:TAG_LSB];

    // Classify the held word into its target set.
    always_comb begin
        sel_s  = 4'b0000;
        drop_s = 1'b0;
        if (dest_s == BROADCAST_ID) begin
            sel_s = RELAY_EN ? 4'b1100 : 4'b0100;
        end else if (dest_s == fpga_id && tag_s == CTRL_TAG) begin
            sel_s = 4'b0100;
        end else if (dest_s == fpga_id && hold_data_r[DIR_BIT]) begin
            sel_s = 4'b0010;
        end else if (dest_s == fpga_id) begin
            sel_s = 4'b0001;
        end else if (RELAY_EN) begin
            sel_s = 4'b1000;
        end else begin
            drop_s = 1'b1;
        end
    end

    assign tgt_valid_s = {4{hold_valid_r}} & sel_s & ~done_r;
    // The relay request only exists while the hold register carries a pending relay target.
    assign req_s = {(RELAY_EN ? tgt_valid_s[3] : 1'b0), ctrl_in_valid, south_in_valid, north_in_valid};

    // Round-robin search starting at the pointer.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = 2'd0;
        idx_s     = 0;
        for (int i = 0; i < NSRC; i++) begin
            idx_s     = (int'(ptr_r) + i) % NSRC;
            gnt_idx_s = (!gnt_any_s && req_s[idx_s]) ? idx_s[1:0] : gnt_idx_s;
            gnt_any_s = gnt_any_s | req_s[idx_s];
        end
    end

    assign ptr_next_s = (gnt_idx_s == 2'(NSRC - 1)) ? 2'd0 : gnt_idx_s + 2'd1;
    assign take_s     = reset && load_s && gnt_any_s;

    // One-hot source readies from the grant.
    always_comb begin
        src_ready_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            src_ready_s[i] = take_s && (gnt_idx_s == 2'(i));
        end
    end

    // Select the granted word and apply the per-direction header rewrite.
    always_comb begin
        egress_word_s = '0;
        case (gnt_idx_s)
            2'd0: begin
                egress_word_s                    = north_in_data;
                egress_word_s[DEST_MSB:DEST_LSB] = north_id_r;
                egress_word_s[DIR_BIT]           = 1'b1;
            end
            2'd1: begin
                egress_word_s                    = south_in_data;
                egress_word_s[DEST_MSB:DEST_LSB] = south_id_r;
                egress_word_s[DIR_BIT]           = 1'b0;
            end
            2'd2:    egress_word_s = ctrl_in_data;
            2'd3:    egress_word_s = hold_data_r;
            default: egress_word_s = '0;
        endcase
    end

    assign hs_s = {src_ready_s[3],
                   tgt_valid_s[2] & ctrl_out_ready,
                   tgt_valid_s[1] & south_out_ready,
                   tgt_valid_s[0] & north_out_ready};

    // A word finishes once no selected target remains outstanding after this cycle.
    assign complete_s = hold_valid_r && (drop_s || ((sel_s & ~(done_r | hs_s)) == 4'b0000));
    assign in_ready_s = reset && (!hold_valid_r || complete_s);

    // Neighbour ids track fpga_id with one cycle of delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            north_id_r <= 8'd0;
            south_id_r <= 8'd0;
        end else begin
            north_id_r <= fpga_id - 8'd1;
            south_id_r <= fpga_id + 8'd1;
        end
    end

    // Egress output register and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            ptr_r       <= 2'd0;
        end else if (load_s) begin
            out_valid_r <= gnt_any_s;
            if (gnt_any_s) begin
                out_data_r <= egress_word_s;
                ptr_r      <= ptr_next_s;
            end
        end
    end

    // Ingress holding register with per-target done flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= '0;
            done_r       <= 4'b0000;
        end else if (in_valid && in_ready_s) begin
            hold_valid_r <= 1'b1;
            hold_data_r  <= in_data;
            done_r       <= 4'b0000;
        end else if (complete_s) begin
            hold_valid_r <= 1'b0;
            done_r       <= 4'b0000;
        end else begin
            done_r       <= done_r | hs_s;
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_r <= '0;
        end else if (hold_valid_r && drop_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
        end
    end

    assign in_ready        = in_ready_s;
    assign out_data        = out_data_r;
    assign out_valid       = out_valid_r;
    assign north_in_ready  = src_ready_s[0];
    assign south_in_ready  = src_ready_s[1];
    assign ctrl_in_ready   = src_ready_s[2];
    assign north_out_data  = hold_data_r;
    assign south_out_data  = hold_data_r;
    assign ctrl_out_data   = hold_data_r;
    assign north_out_valid = tgt_valid_s[0];
    assign south_out_valid = tgt_valid_s[1];
    assign ctrl_out_valid  = tgt_valid_s[2];
    assign drop_count      = drop_cnt_r;
    assign router_busy     = hold_valid_r | out_valid_r | north_in_valid | south_in_valid;

endmodule

// File: doc/gt_message_router.md
Name: gt_message_router

Overview:
- Second-generation inter-FPGA message handler between the GT transceiver link and the local border/control channels.
- Egress: round-robin arbitration of north border, south border, control and relay traffic into one registered GT output, with per-direction header rewrite.
- Ingress: one-entry holding register that classifies each GT word by destination and tag, and delivers it to the north border, south border or control.
- Non-local words are relayed onto the link or dropped and counted. Broadcasts are multicast to control and, optionally, relayed.

Parameters:
- GT_WIDTH, 64, width of every message port.
- DEST_MSB, 63, destination FPGA id field MSB.
- DEST_LSB, 56, destination FPGA id field LSB (field is exactly 8 bits).
- DIR_BIT, 55, direction tag bit. 1 = sent northward, 0 = sent southward.
- TAG_MSB, 54, channel tag MSB.
- TAG_LSB, 48, channel tag LSB.
- CTRL_TAG, 7'h7F, channel tag value marking a control message.
- BROADCAST_ID, 8'hFF, broadcast destination id.
- RELAY_EN, 1, 1 = forward non-local words and broadcasts back onto the link. 0 = drop non-local words.
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- fpga_id  in  8  own FPGA id; quasi-static.
- in_data  in  GT_WIDTH  word from the GT link.
- in_valid  in  1  in_data valid.
- in_ready  out  1  ingress accepts.
- out_data  out  GT_WIDTH  word to the GT link.
- out_valid  out  1  out_data valid.
- out_ready  in  1  link accepts.
- north_in_data / north_in_valid / north_in_ready  in / in / out  GT_WIDTH / 1 / 1  combined north border traffic to send.
- south_in_data / south_in_valid / south_in_ready  in / in / out  GT_WIDTH / 1 / 1  combined south border traffic to send.
- ctrl_in_data / ctrl_in_valid / ctrl_in_ready  in / in / out  GT_WIDTH / 1 / 1  control traffic to send.
- north_out_data / north_out_valid / north_out_ready  out / out / in  GT_WIDTH / 1 / 1  received north border traffic.
- south_out_data / south_out_valid / south_out_ready  out / out / in  GT_WIDTH / 1 / 1  received south border traffic.
- ctrl_out_data / ctrl_out_valid / ctrl_out_ready  out / out / in  GT_WIDTH / 1 / 1  received control traffic.
- drop_count  out  CNT_WIDTH  saturating count of dropped words.
- router_busy  out  1  any traffic in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, out_data=0, hold register empty, done flags cleared, RR pointer=north, drop_count=0, neighbour id registers=0.
  - All *_valid and *_ready outputs read 0 while in reset.
  - Reset mid-transfer discards any held or registered word without a partial handshake.
- Neighbour ids are registered every cycle:
  - north_id = fpga_id-1 (mod 256), south_id = fpga_id+1 (mod 256).
  - Header rewrite takes effect 1 cycle after an fpga_id change.
- Egress: single output register, load condition load = !out_valid || out_ready.
  - Requesters in RR order: N, S, C, R (R present only if RELAY_EN).
  - On load, grant the first requester at or after the pointer; the pointer then moves to grant+1.
  - Only the granted source's ready is 1; readies are combinational, with no valid-to-ready dependency on the source itself.
  - N word: DEST field ← north_id, DIR_BIT ← 1, all other bits unchanged.
  - S word: DEST ← south_id, DIR_BIT ← 0. C and R words pass unmodified.
  - Latency: source handshake → out_valid next cycle. Back-to-back throughput is 1 word/cycle while out_ready=1.
  - out_data is stable while out_valid && !out_ready.
- Ingress: in_ready = hold empty, or the held word completes this cycle (zero-bubble).
- Classification of the held word (dest = DEST field, tag = TAG field):
  - dest==BROADCAST_ID → targets {C} plus {R if RELAY_EN}.
  - dest==fpga_id && tag==CTRL_TAG → {C}.
  - dest==fpga_id && DIR_BIT=1 → {south_out}. dest==fpga_id && DIR_BIT=0 → {north_out}.
  - Otherwise → {R} if RELAY_EN; else dropped.
- Delivery:
  - Each target's valid = hold_valid && target selected && !done[target]. All targets see the same data.
  - Each target handshake sets its done flag.
  - The word completes when all selected targets are done, or same-cycle handshakes finish the set; the hold register and done flags are then cleared.
  - Head-of-line blocking is intentional.
- Drop:
  - A dropped word completes in the cycle after capture.
  - drop_count increments by 1 and saturates at all-ones.
- Relay/egress interaction:
  - R is the relay request into the egress arbiter. Relay uses hold data directly, so R's ready equals R's grant.
  - The arbiter never grants R in the same cycle the hold register is empty.
- router_busy = hold_valid | out_valid | north_in_valid | south_in_valid.

Test Plan:
- fpga_id=5; N sends 64'h00AA_... with out_ready=1 → next cycle out_data[63:56]=8'h04, bit55=1, other bits identical. Same with S → 8'h06, bit55=0.
- N, S and C all valid for 6 cycles, out_ready=1 → grant order N,S,C,N,S,C, one word/cycle. Holding out_ready=0 for 3 cycles keeps out_data stable and all readies at 0.
- fpga_id=5; in words {dest=05,bit55=1}, {dest=05,bit55=0}, {dest=05,tag=7F} → delivered to south_out, north_out and ctrl_out respectively. Back-to-back with all readies=1 gives in_ready=1 every cycle.
- RELAY_EN=1, broadcast dest=FF, ctrl_out_ready=1, out_ready=0 for 4 cycles → ctrl taken once (no re-assert), in_ready=0 until the relay handshake, then out_data equals the input word.
- RELAY_EN=0, 3 words with dest=09 → each dropped, drop_count=3. With CNT_WIDTH=2, 5 drops leave drop_count=3.
- Assert reset while out_valid=1 and the hold register is full → all valids 0 immediately, drop_count=0; after release the first new word is handled normally.
